conv1_pool_reader: RTL and testbench

- Drains the CONV1 output FIFO from the read side. The convolution datapath is the FIFO writer; this block is the FIFO reader.
- Consumes conv1 feature-map samples in row-major order and applies 2x2, stride-2 max pooling.
- Emits pooled samples on a valid/ready stream to the next LeNet layer (S2/CONV2 input).
- Pulses a done flag once per completed feature map.

---
 rtl/conv1_pool_reader_if.sv | 23 ++
 rtl/conv1_pool_reader.sv | 112 +++++++++++
 tb/tb_conv1_pool_reader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_pool_reader_if.sv
// Read side of the conv1 FIFO plus the pooled-sample valid/ready stream.
// master = pooling reader, slave = FIFO/downstream side.
interface conv1_pool_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  pool_valid;
  logic                  pool_ready;
  logic [DATA_WIDTH-1:0] pool_data;
  logic                  pool_done;

  modport master (
    input  fifo_empty, fifo_data, pool_ready,
    output fifo_rd_en, pool_valid, pool_data, pool_done
  );

  modport slave (
    output fifo_empty, fifo_data, pool_ready,
    input  fifo_rd_en, pool_valid, pool_data, pool_done
  );
endinterface

// File: rtl/conv1_pool_reader.sv
// Drains the conv1 FIFO and emits 2x2 stride-2 max-pooled samples; output registered 1 cycle after
// the window-completing datum arrives. A stalled output blocks further FIFO reads; in-flight data is absorbed.
module conv1_pool_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int FMAP_WIDTH  = 28,
  parameter int SIGNED_DATA = 1
) (
  input  logic                clk,
  input  logic                rst,
  conv1_pool_reader_if.master bus
);
  localparam int HALF = FMAP_WIDTH / 2;
  localparam int CW   = (FMAP_WIDTH > 2) ? $clog2(FMAP_WIDTH) : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int NOUT = HALF * HALF;
  localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [CW-1:0] POS_LAST = CW'(FMAP_WIDTH - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

  logic [CW-1:0]         col_q, col_d, row_q, row_d;
  logic                  rd_pending_q;
  logic [DATA_WIDTH-1:0] hreg_q, hreg_d;
  logic [DATA_WIDTH-1:0] linebuf_q [HALF];
  logic                  pool_valid_q, pool_valid_d;
  logic [DATA_WIDTH-1:0] pool_data_q, pool_data_d;
  logic                  pool_done_q, pool_done_d;
  logic [OW-1:0]         out_cnt_q, out_cnt_d;
  logic                  rd_en, xfer, col_odd, row_odd, lb_wr;
  logic [HW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] hmax, vmax;

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_DATA != 0) return ($signed(a) >= $signed(b)) ? a : b;
    return (a >= b) ? a : b;
  endfunction

  always_comb begin
    rd_en        = !bus.fifo_empty && (!pool_valid_q || bus.pool_ready);
    xfer         = pool_valid_q && bus.pool_ready;
    col_odd      = col_q[0];
    row_odd      = row_q[0];
    lb_idx       = HW'(col_q >> 1);
    hmax         = max2(hreg_q, bus.fifo_data);
    vmax         = max2(linebuf_q[lb_idx], hmax);
    lb_wr        = rd_pending_q && col_odd && !row_odd;
    col_d        = col_q;
    row_d        = row_q;
    hreg_d       = hreg_q;
    pool_valid_d = pool_valid_q && !xfer;
    pool_data_d  = pool_data_q;
    pool_done_d  = 1'b0;
    out_cnt_d    = out_cnt_q;

    if (rd_pending_q) begin
      if (col_q == POS_LAST) begin
        col_d = '0;
        row_d = (row_q == POS_LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_odd) begin
        hreg_d = bus.fifo_data;
      end else if (row_odd) begin
        // Window-completing data are >= 2 reads apart and reads stop on stall, so no overwrite.
        pool_valid_d = 1'b1;
        pool_data_d  = vmax;
      end
    end

    if (xfer) begin
      if (out_cnt_q == OUT_LAST) begin
        out_cnt_d   = '0;
        pool_done_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      rd_pending_q <= 1'b0;
      hreg_q       <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      pool_done_q  <= 1'b0;
      out_cnt_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      rd_pending_q <= rd_en;
      hreg_q       <= hreg_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
      pool_done_q  <= pool_done_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  // Line buffer is always rewritten by an even row before it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lb_wr) linebuf_q[lb_idx] <= hmax;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.pool_valid = pool_valid_q;
  assign bus.pool_data  = pool_data_q;
  assign bus.pool_done  = pool_done_q;
endmodule

// File: tb/tb_conv1_pool_reader.sv
// Directed and randomized checks of conv1_pool_reader against a frame-level pooling model.
`timescale 1ns/1ps
module tb_conv1_pool_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        emp [3];
  logic        rdy [3];
  logic [15:0] dat [3];
  logic        rd  [3];
  logic        vld [3];
  logic        done[3];
  logic [15:0] pd  [3];

  conv1_pool_reader_if #(.DATA_WIDTH(8))  if0 ();
  conv1_pool_reader_if #(.DATA_WIDTH(8))  if1 ();
  conv1_pool_reader_if #(.DATA_WIDTH(16)) if2 ();

  conv1_pool_reader #(.DATA_WIDTH(8), .FMAP_WIDTH(4), .SIGNED_DATA(0))
    u0 (.clk(clk), .rst(rst), .bus(if0.master));
  conv1_pool_reader #(.DATA_WIDTH(8), .FMAP_WIDTH(4), .SIGNED_DATA(1))
    u1 (.clk(clk), .rst(rst), .bus(if1.master));
  conv1_pool_reader #(.DATA_WIDTH(16), .FMAP_WIDTH(28), .SIGNED_DATA(1))
    u2 (.clk(clk), .rst(rst), .bus(if2.master));

  assign if0.fifo_empty = emp[0];
  assign if0.fifo_data  = dat[0][7:0];
  assign if0.pool_ready = rdy[0];
  assign rd[0]   = if0.fifo_rd_en;
  assign vld[0]  = if0.pool_valid;
  assign done[0] = if0.pool_done;
  assign pd[0]   = {8'h00, if0.pool_data};

  assign if1.fifo_empty = emp[1];
  assign if1.fifo_data  = dat[1][7:0];
  assign if1.pool_ready = rdy[1];
  assign rd[1]   = if1.fifo_rd_en;
  assign vld[1]  = if1.pool_valid;
  assign done[1] = if1.pool_done;
  assign pd[1]   = {8'h00, if1.pool_data};

  assign if2.fifo_empty = emp[2];
  assign if2.fifo_data  = dat[2];
  assign if2.pool_ready = rdy[2];
  assign rd[2]   = if2.fifo_rd_en;
  assign vld[2]  = if2.pool_valid;
  assign done[2] = if2.pool_done;
  assign pd[2]   = if2.pool_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] img [784];
  logic [15:0] in_q [$];
  logic [15:0] exp_q [$];
  int          out_cnt, done_cnt, per_map, rd_n, first_vld, rd5_cyc, cyc;
  bit          done_exp, hold_chk;
  logic [15:0] hold_pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int fw(input int d);
    return (d < 2) ? 4 : 28;
  endfunction

  function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b, input int d);
    int sa, sb;
    if (d == 0) begin
      sa = int'(a); sb = int'(b);
    end else if (d == 1) begin
      sa = int'($signed(a[7:0])); sb = int'($signed(b[7:0]));
    end else begin
      sa = int'($signed(a)); sb = int'($signed(b));
    end
    return (sa >= sb) ? a : b;
  endfunction

  task automatic new_test(input int d);
    in_q.delete();
    exp_q.delete();
    out_cnt = 0; done_cnt = 0; done_exp = 0; hold_chk = 0;
    rd_n = 0; first_vld = -1; rd5_cyc = 0;
    per_map = (fw(d) / 2) * (fw(d) / 2);
  endtask

  task automatic rand_img(input int d);
    for (int i = 0; i < 784; i++)
      img[i] = (d < 2) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
  endtask

  task automatic add_map(input int d);
    int w;
    logic [15:0] m;
    w = fw(d);
    for (int i = 0; i < w * w; i++) in_q.push_back(img[i]);
    for (int pr = 0; pr < w / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++) begin
        m = mx(mx(img[2*pr*w + 2*pc], img[2*pr*w + 2*pc + 1], d),
               mx(img[(2*pr+1)*w + 2*pc], img[(2*pr+1)*w + 2*pc + 1], d), d);
        exp_q.push_back(m);
      end
  endtask

  // One clock cycle: drive at negedge, check, then deliver FIFO data just after the edge.
  task automatic step(input int d, input bit e, input bit r);
    bit take;
    @(negedge clk);
    emp[d] = e || (in_q.size() == 0);
    rdy[d] = r;
    #1;
    chk("fifo_rd_en", rd[d], !emp[d] && (!vld[d] || rdy[d]));
    chk("pool_done", done[d], done_exp);
    if (hold_chk) begin
      chk("hold_valid", vld[d], 1);
      chk("hold_data", pd[d], hold_pd);
    end
    if (vld[d] && first_vld < 0) first_vld = cyc;
    if (done[d]) done_cnt++;
    done_exp = 0;
    if (vld[d] && rdy[d]) begin
      chk("output_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("pool_data", pd[d], exp_q.pop_front());
      out_cnt++;
      if (out_cnt % per_map == 0) done_exp = 1;
    end
    hold_chk = vld[d] && !rdy[d];
    hold_pd  = pd[d];
    take = rd[d];
    if (take) begin
      if (rd_n == 5) rd5_cyc = cyc;
      rd_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (take && in_q.size() != 0) dat[d] = in_q.pop_front();
  endtask

  task automatic drain(input int d, input bit rnd, input int maps);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || vld[d]) && n < 20000) begin
      step(d, rnd ? ($urandom_range(0, 1) == 1) : 1'b0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    chk("drain_within_budget", n < 20000, 1);
    step(d, 1'b1, 1'b1);
    step(d, 1'b1, 1'b1);
    chk("outputs_per_test", out_cnt, maps * per_map);
    chk("done_pulses", done_cnt, maps);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    for (int i = 0; i < 3; i++) begin
      emp[i] = 1'b1; rdy[i] = 1'b1; dat[i] = '0;
    end
    cyc = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", vld[i], 0);
      chk("reset_data", pd[i], 0);
      chk("reset_done", done[i], 0);
      chk("reset_rd_en", rd[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Ramp 0..15: pooled 5,7,13,15 and latency from the read of value 5.
    new_test(0);
    for (int i = 0; i < 16; i++) img[i] = 16'(i);
    add_map(0);
    drain(0, 1'b0, 1);
    chk("first_valid_latency", first_vld - rd5_cyc, 2);

    // Negative window and 0x7F/0x80 window, signed and unsigned.
    rand_img(0);
    img[0] = 16'hFD; img[1] = 16'hFF; img[4] = 16'hF8; img[5] = 16'hFE;
    img[2] = 16'h7F; img[3] = 16'h80; img[6] = 16'h01; img[7] = 16'h02;
    new_test(1);
    add_map(1);
    drain(1, 1'b0, 1);
    new_test(0);
    add_map(0);
    drain(0, 1'b0, 1);

    // Output stall for 10 cycles.
    new_test(0);
    rand_img(0);
    add_map(0);
    g = 0;
    while (!vld[0] && g < 50) begin
      step(0, 1'b0, 1'b1);
      g++;
    end
    chk("stall_reached_valid", vld[0], 1);
    repeat (10) step(0, 1'b0, 1'b0);
    drain(0, 1'b0, 1);

    // All-equal inputs.
    for (int i = 0; i < 16; i++) img[i] = 16'h40;
    new_test(0);
    add_map(0);
    drain(0, 1'b0, 1);
    new_test(1);
    add_map(1);
    drain(1, 1'b0, 1);

    // Two back-to-back 28x28 maps with random empty and ready.
    new_test(2);
    rand_img(2);
    add_map(2);
    rand_img(2);
    add_map(2);
    drain(2, 1'b1, 2);

    // Asynchronous reset mid-row 1 while a pooled sample is held.
    new_test(0);
    for (int i = 0; i < 16; i++) img[i] = 16'(i + 32);
    for (int i = 0; i < 6; i++) in_q.push_back(img[i]);
    repeat (12) step(0, 1'b0, 1'b0);
    chk("pre_reset_valid", vld[0], 1);
    chk("pre_reset_data", pd[0], 16'h25);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", vld[0], 0);
    chk("async_reset_data", pd[0], 0);
    chk("async_reset_done", done[0], 0);
    @(negedge clk);
    rst = 1'b0;
    new_test(0);
    rand_img(0);
    add_map(0);
    drain(0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
